hex_state_display: RTL

HEX_STATE_DISPLAY -- requirements
Module: hex_state_display

---
 rtl/hex_state_display.sv | 94 +++++++++
 1 files changed

// File: rtl/hex_state_display.sv
// Multi-digit hex display driven by a game state.
// Shows committed values for past digits and a blinking live value for the current digit.
module hex_state_display #(
  parameter int         N_DIG      = 4,
  parameter int         STATE_W    = 3,
  parameter int         BLINK_DIV  = 25_000_000,
  parameter logic [3:0] BLANK_CODE = 4'hE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [STATE_W-1:0]   estado_jogo,
  input  logic [3:0]           switch_cod,
  input  logic                 confirma,
  input  logic                 limpa,
  output logic [4*N_DIG-1:0]   hex_out,
  output logic [4*N_DIG-1:0]   valor_regs,
  output logic                 fase_pisca
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               fase_reg, fase_next;
  logic [STATE_W-1:0] prev_state_reg;
  logic               state_changed;
  logic               game_over;

  assign state_changed = (estado_jogo != prev_state_reg);
  // Extra bit keeps the comparison valid when N_DIG == 2**STATE_W.
  assign game_over     = ({1'b0, estado_jogo} >= (STATE_W+1)'(N_DIG));
  assign fase_pisca    = fase_reg;

  always_comb begin
    cnt_next  = cnt_reg + 1'b1;
    fase_next = fase_reg;
    if (state_changed) begin
      cnt_next  = '0;
      fase_next = 1'b1;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_next  = '0;
      fase_next = ~fase_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      fase_reg       <= 1'b1;
      prev_state_reg <= '0;
    end else begin
      cnt_reg        <= cnt_next;
      fase_reg       <= fase_next;
      prev_state_reg <= estado_jogo;
    end
  end

  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_digit
    localparam logic [STATE_W-1:0] IDX = STATE_W'(gi);

    logic [3:0] digit_reg;
    logic [3:0] hex_reg;
    logic [3:0] shown;

    always_ff @(posedge clk) begin
      if (reset || limpa) begin
        digit_reg <= 4'h0;
      end else if (confirma && (estado_jogo == IDX)) begin
        digit_reg <= switch_cod;
      end
    end

    always_comb begin
      shown = BLANK_CODE;
      if (game_over || (estado_jogo > IDX)) begin
        shown = digit_reg;
      end else if ((estado_jogo == IDX) && fase_reg) begin
        shown = switch_cod;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        hex_reg <= BLANK_CODE;
      end else begin
        hex_reg <= shown;
      end
    end

    assign hex_out[4*gi +: 4]    = hex_reg;
    assign valor_regs[4*gi +: 4] = digit_reg;
  end

endmodule
